// File: rtl/ram_responder.sv
// ram_responder: word RAM slave with LAT wait states and a ramwait handshake.
// Define RAM_ADDR_CHECK_EN to send out-of-range addresses to ERROR instead of aliasing them.
module ram_responder #(
  parameter int DEPTH = 1024,
  parameter int LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        ramwait,
  output logic [1:0]  ramstate
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LAT > 0 ? $clog2(LAT + 1) : 1;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, load_q, load_d;
  logic [31:0] mem [DEPTH];
  logic one, both, bad, changed;
  assign one = ramREN ^ ramWEN;
  assign both = ramREN & ramWEN;
  assign changed = {ramWEN, ramaddr, ramstore} != {op_q, addr_q, data_q};
`ifdef RAM_ADDR_CHECK_EN
  assign bad = |ramaddr[31:AW+2];
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      FREE, BUSY:
        if (both) state_d = ERROR;
        else if (!one) state_d = FREE;
        else if (state_q == FREE || changed) begin
          op_d = ramWEN;
          addr_d = ramaddr;
          data_d = ramstore;
          cnt_d = '0;
          state_d = bad ? ERROR : (LAT == 0 ? ACCESS : BUSY);
        end
        else if (cnt_q == CW'(LAT - 1)) state_d = ACCESS;
        else cnt_d = cnt_q + CW'(1);
      ACCESS: state_d = FREE;
      default: state_d = (both || (one && bad)) ? ERROR : FREE;
    endcase
    // Capture read data on entry so ramload is already valid during the ACCESS cycle
    load_d = (state_d == ACCESS && !op_d) ? mem[addr_d[AW+1:2]] : load_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FREE;
      cnt_q <= '0;
      op_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      load_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      addr_q <= addr_d;
      data_q <= data_d;
      load_q <= load_d;
    end
  end
  always_ff @(posedge CLK)
    if (!RST && state_q == ACCESS && op_q) mem[addr_q[AW+1:2]] <= data_q;
  assign ramload = load_q;
  assign ramwait = state_q != ACCESS;
  assign ramstate = state_q;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed bench for ram_responder at LAT=2 and LAT=0 against a per-instance request-run model.
module tb_ram_responder;
  localparam int DEPTH = 1024;
  localparam int AW = $clog2(DEPTH);
  logic CLK = 0, RST = 1, ren = 0, wen = 0;
  logic [31:0] addr = 0, store = 0;
  logic [31:0] load [2];
  logic wt [2];
  logic [1:0] st [2];
  int tests = 0, fails = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int L = g == 0 ? 2 : 0;
    ram_responder #(.DEPTH(DEPTH), .LAT(L)) dut (
      .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
      .ramstore(store), .ramload(load[g]), .ramwait(wt[g]), .ramstate(st[g]));
    // Model: an access completes once the same single request has been seen for L+1 cycles in a row
    logic [31:0] mm [DEPTH];
    logic h_w = 0;
    logic [31:0] h_a = 0, h_s = 0, eload = 0;
    int run = -1;
    bit done = 0, err = 0, armed = 0;
    always @(posedge CLK) begin
      bit bad, one, both;
      bad = 0;
`ifdef RAM_ADDR_CHECK_EN
      bad = addr[31:AW+2] != 0;
`endif
      one = ren ^ wen;
      both = ren & wen;
      if (RST) begin
        run = -1; done = 0; err = 0; eload = 0; armed = 1;
      end else if (done) begin
        if (h_w) mm[h_a[AW+1:2]] = h_s;
        done = 0;
      end else if (err) err = both || (one && bad);
      else if (both) begin
        err = 1; run = -1;
      end else if (!one) run = -1;
      else begin
        if (run < 0 || {wen, addr, store} != {h_w, h_a, h_s}) begin
          h_w = wen; h_a = addr; h_s = store; run = 0;
        end else run++;
        if (bad) begin
          err = 1; run = -1;
        end else if (run == L) begin
          done = 1; run = -1;
          if (!h_w) eload = mm[h_a[AW+1:2]];
        end
      end
    end
    always @(negedge CLK) if (armed) begin
      chk($sformatf("m%0d.state", g), 32'(st[g]), err ? 32'd3 : done ? 32'd2 : run >= 0 ? 32'd1 : 32'd0);
      chk($sformatf("m%0d.wait", g), 32'(wt[g]), 32'(!done));
      chk($sformatf("m%0d.load", g), load[g], eload);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] s);
    ren = r; wen = w; addr = a; store = s;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0);
    step(3);
  endtask
  task automatic finish_access(input string name);
    for (int i = 0; i < 20; i++) begin
      step();
      if (wt[0] === 1'b0) break;
    end
    chk(name, 32'(wt[0]), 32'd0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] s);
    drive(0, 1, a, s);
    finish_access("wr_done");
    idle();
  endtask

  initial begin
    step(2);
    chk("rst_state", 32'(st[0]), 0);
    chk("rst_wait", 32'(wt[0]), 1);
    chk("rst_load", load[0], 0);
    chk("rst_state1", 32'(st[1]), 0);
    RST = 0;
    step();
    drive(0, 1, 32'h40, 32'hDEADBEEF);
    step(); chk("wr40_c1", 32'(st[0]), 1);
    step(); chk("wr40_c2", 32'(st[0]), 1);
    step(); chk("wr40_c3", 32'(st[0]), 2); chk("wr40_wait", 32'(wt[0]), 0);
    idle();
    drive(1, 0, 32'h40, 0);
    finish_access("rd40_done"); chk("rd40", load[0], 32'hDEADBEEF);
    idle();
    drive(0, 1, 32'h40, 32'h00000BAD);
    step(); chk("drop_busy", 32'(st[0]), 1);
    drive(0, 0, 0, 0);
    step(); chk("drop_free", 32'(st[0]), 0);
    step();
    drive(1, 0, 32'h40, 0);
    finish_access("rd40b_done"); chk("rd40_nowrite", load[0], 32'hDEADBEEF);
    idle();
    wr(32'h44, 32'h12345678);
    drive(1, 0, 32'h40, 0);
    step(2); chk("rst_busy2", 32'(st[0]), 1);
    addr = 32'h44;
    step(); chk("restart_st", 32'(st[0]), 1); chk("restart_w1", 32'(wt[0]), 1);
    step(); chk("restart_w2", 32'(wt[0]), 1);
    step(); chk("restart_w3", 32'(wt[0]), 0); chk("restart_ld", load[0], 32'h12345678);
    idle();
    drive(1, 1, 32'h40, 0);
    step(); chk("err_st", 32'(st[0]), 3); chk("err_wait", 32'(wt[0]), 1);
    step(); chk("err_hold", 32'(st[0]), 3);
    wen = 0;
    step(); chk("err_free", 32'(st[0]), 0);
    finish_access("err_rd_done"); chk("err_rd", load[0], 32'hDEADBEEF);
    idle();
    wr(32'h0, 32'hA0A0A0A0);
    wr(32'h4, 32'hB4B4B4B4);
    drive(1, 0, 32'h0, 0);
    step(); chk("l0_st", 32'(st[1]), 2); chk("l0_w1", 32'(wt[1]), 0); chk("l0_ld0", load[1], 32'hA0A0A0A0);
    step(); chk("l0_w2", 32'(wt[1]), 1);
    step(); chk("l0_w3", 32'(wt[1]), 0); chk("l0_ld0b", load[1], 32'hA0A0A0A0);
    addr = 32'h4;
    step(); chk("l0_w4", 32'(wt[1]), 1);
    step(); chk("l0_w5", 32'(wt[1]), 0); chk("l0_ld4", load[1], 32'hB4B4B4B4);
    idle();
    wr(32'h80, 32'h11111111);
    drive(0, 1, 32'h80, 32'h22222222);
    finish_access("wr80_done");
    RST = 1;
    step(); chk("abort_st", 32'(st[0]), 0); chk("abort_ld", load[0], 0); chk("abort_w", 32'(wt[0]), 1);
    RST = 0;
    idle();
    drive(1, 0, 32'h80, 0);
    finish_access("rd80_done"); chk("rd80", load[0], 32'h11111111);
    idle();
    drive(1, 0, 32'h1000, 0);
`ifdef RAM_ADDR_CHECK_EN
    step(2); chk("oor_err", 32'(st[0]), 3);
`else
    finish_access("alias_done"); chk("alias_ld", load[0], 32'hA0A0A0A0);
`endif
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
